// File: rtl/jts16_gfx_arb.sv
// Graphics SDRAM read-port arbiter for the S16 video path.
// Each requester has a one-entry tag/data buffer; misses are served round-robin, one at a time.
module jts16_gfx_arb #(
  parameter int N  = 6,
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [N-1:0]  req_cs,
  input  logic [N*AW-1:0] req_addr,
  output logic [N-1:0]  req_ok,
  output logic [N*DW-1:0] req_data,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_rd,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [DW-1:0] sdram_din,
  output logic          busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ACK, DATA} state_t;

  state_t         state, next_state;
  logic [N-1:0]   valid, hit, miss;
  logic [AW-1:0]  tag  [N];
  logic [DW-1:0]  data [N];
  logic [IW-1:0]  rr, grant, sel, idx;
  logic [AW-1:0]  pend_tag;
  logic           discard, found, capture;

  always_comb begin
    hit      = '0;
    req_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hit[i] = req_cs[i] & valid[i] & (req_addr[i*AW +: AW] == tag[i]);
      req_data[i*DW +: DW] = data[i];
    end
    req_ok = hit;
    miss   = req_cs & ~hit;
  end

  // First miss at or after rr, wrapping modulo N
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(rr) + k) % N);
      if (!found && miss[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Same-cycle ack+rdy in ACK is treated as ack followed by rdy
  assign capture = ((state == ACK) && sdram_ack && sdram_rdy) ||
                   ((state == DATA) && sdram_rdy);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (found) next_state = ACK;
      ACK:     if (sdram_ack) next_state = sdram_rdy ? IDLE : DATA;
      DATA:    if (sdram_rdy) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr         <= '0;
      sel        <= '0;
      valid      <= '0;
      pend_tag   <= '0;
      discard    <= 1'b0;
      sdram_rd   <= 1'b0;
      sdram_addr <= '0;
      busy       <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      if (flush) discard <= 1'b1;
      case (state)
        IDLE: begin
          if (found) begin
            sel        <= grant;
            sdram_addr <= req_addr[grant*AW +: AW];
            pend_tag   <= req_addr[grant*AW +: AW];
            sdram_rd   <= 1'b1;
            busy       <= 1'b1;
            discard    <= 1'b0;
            rr         <= (grant == IW'(N-1)) ? '0 : grant + 1'b1;
          end
        end
        ACK:     if (sdram_ack) sdram_rd <= 1'b0;
        default: ;
      endcase
      if (capture) begin
        busy <= 1'b0;
        if (!discard && !flush) begin
          valid[sel] <= 1'b1;
          tag[sel]   <= pend_tag;
          data[sel]  <= sdram_din;
        end
      end
      // Flush overrides any capture in the same cycle
      if (flush) valid <= '0;
    end
  end

endmodule

// File: tb/tb_jts16_gfx_arb.sv
// Directed self-checking bench for jts16_gfx_arb; SDRAM handshakes are driven by hand.
module tb_jts16_gfx_arb;
  localparam int N  = 6;
  localparam int AW = 22;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [N-1:0]    req_cs;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ok;
  logic [N*DW-1:0] req_data;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_rd;
  logic            sdram_ack;
  logic            sdram_rdy;
  logic [DW-1:0]   sdram_din;
  logic            busy;

  int compared = 0;
  int mismatched = 0;

  jts16_gfx_arb #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_cs(req_cs), .req_addr(req_addr),
    .req_ok(req_ok), .req_data(req_data), .sdram_addr(sdram_addr), .sdram_rd(sdram_rd),
    .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .sdram_din(sdram_din), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rdata(input int i);
    return req_data[i*DW +: DW];
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; flush = 1'b0; req_cs = '0; req_addr = '0;
    sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Wait for a grant, record its address, then ack and one cycle later rdy
  task automatic serve(input logic [DW-1:0] din, output logic [AW-1:0] addr_seen);
    int n = 0;
    while (!sdram_rd && n < 20) begin tick(); n++; end
    compared++;
    if (!sdram_rd) begin
      mismatched++;
      $display("FAIL serve_timeout: sdram_rd=%b after %0d cycles, required 1", sdram_rd, n);
    end
    addr_seen = sdram_addr;
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    sdram_din = din; sdram_rdy = 1'b1; tick(); sdram_rdy = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    compared++;
    if ({req_ok, sdram_rd, busy} !== '0 || sdram_addr !== '0 || req_data !== '0) begin
      mismatched++;
      $display("FAIL reset: req_ok=%b rd=%b busy=%b addr=%h, required all zero",
               req_ok, sdram_rd, busy, sdram_addr);
    end
  endtask

  task automatic test_single_miss();
    apply_reset();
    req_cs = 6'b000100; set_addr(2, 22'h01234);
    tick();
    compared++;
    if (sdram_rd !== 1'b1 || sdram_addr !== 22'h01234 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL single_grant: rd=%b addr=%h busy=%b, required 1 01234 1", sdram_rd, sdram_addr, busy);
    end
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    compared++;
    if (sdram_rd !== 1'b0 || busy !== 1'b1 || req_ok[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL single_ack: rd=%b busy=%b ok=%b, required 0 1 0", sdram_rd, busy, req_ok[2]);
    end
    sdram_din = 32'hA5A5_5A5A; sdram_rdy = 1'b1; tick(); sdram_rdy = 1'b0;
    compared++;
    if (req_ok !== 6'b000100 || rdata(2) !== 32'hA5A5_5A5A || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL single_data: ok=%b data=%h busy=%b, required 000100 a5a55a5a 0", req_ok, rdata(2), busy);
    end
    req_cs = '0; tick();
    req_cs = 6'b000100;
    for (int c = 0; c < 3; c++) begin
      tick();
      compared++;
      if (sdram_rd !== 1'b0 || req_ok[2] !== 1'b1) begin
        mismatched++;
        $display("FAIL single_hit: cycle %0d rd=%b ok=%b, required 0 1", c, sdram_rd, req_ok[2]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] a;
    logic [AW-1:0] exp_addr [5] = '{22'h000010, 22'h000030, 22'h000050, 22'h000011, 22'h000051};
    apply_reset();
    set_addr(0, 22'h000010); set_addr(3, 22'h000030); set_addr(5, 22'h000050);
    req_cs = 6'b101001;
    for (int g = 0; g < 3; g++) begin
      serve(32'h1000_0000 + 32'(g), a);
      compared++;
      if (a !== exp_addr[g]) begin
        mismatched++;
        $display("FAIL rr_grant%0d: addr=%h, required %h", g, a, exp_addr[g]);
      end
    end
    compared++;
    if (req_ok !== 6'b101001 || rdata(3) !== 32'h1000_0001 || rdata(5) !== 32'h1000_0002) begin
      mismatched++;
      $display("FAIL rr_data: ok=%b d3=%h d5=%h, required 101001 10000001 10000002", req_ok, rdata(3), rdata(5));
    end
    req_cs = 6'b100001; set_addr(0, 22'h000011); set_addr(5, 22'h000051);
    for (int g = 3; g < 5; g++) begin
      serve(32'h2000_0000 + 32'(g), a);
      compared++;
      if (a !== exp_addr[g]) begin
        mismatched++;
        $display("FAIL rr_wrap%0d: addr=%h, required %h", g, a, exp_addr[g]);
      end
    end
    req_cs = '0;
  endtask

  task automatic test_addr_change();
    logic [AW-1:0] a;
    req_cs = 6'b000010; set_addr(1, 22'h000100);
    tick();
    compared++;
    if (sdram_rd !== 1'b1 || sdram_addr !== 22'h000100) begin
      mismatched++;
      $display("FAIL chg_grant: rd=%b addr=%h, required 1 000100", sdram_rd, sdram_addr);
    end
    set_addr(1, 22'h000104);
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    sdram_din = 32'h0000_0100; sdram_rdy = 1'b1; tick(); sdram_rdy = 1'b0;
    compared++;
    if (req_ok[1] !== 1'b0) begin
      mismatched++;
      $display("FAIL chg_ok_low: ok=%b, required 0", req_ok[1]);
    end
    set_addr(1, 22'h000100); #1;
    compared++;
    if (req_ok[1] !== 1'b1 || rdata(1) !== 32'h0000_0100) begin
      mismatched++;
      $display("FAIL chg_old_tag: ok=%b data=%h, required 1 00000100", req_ok[1], rdata(1));
    end
    set_addr(1, 22'h000104);
    serve(32'h0000_0104, a);
    compared++;
    if (a !== 22'h000104 || req_ok[1] !== 1'b1 || rdata(1) !== 32'h0000_0104) begin
      mismatched++;
      $display("FAIL chg_refetch: addr=%h ok=%b data=%h, required 000104 1 00000104", a, req_ok[1], rdata(1));
    end
    req_cs = '0;
  endtask

  task automatic test_flush();
    logic [AW-1:0] a;
    req_cs = 6'b010000; set_addr(4, 22'h000200);
    tick();
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    sdram_din = 32'hBAD0_BAD0; sdram_rdy = 1'b1; flush = 1'b1;
    tick();
    sdram_rdy = 1'b0; flush = 1'b0;
    compared++;
    if (req_ok[4] !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_rdy: ok=%b busy=%b, required 0 0", req_ok[4], busy);
    end
    serve(32'h0000_0200, a);
    compared++;
    if (a !== 22'h000200 || req_ok[4] !== 1'b1 || rdata(4) !== 32'h0000_0200) begin
      mismatched++;
      $display("FAIL flush_refetch: addr=%h ok=%b data=%h, required 000200 1 00000200", a, req_ok[4], rdata(4));
    end
    // Requester 1 was valid at 104 before the flush
    req_cs = 6'b000010; #1;
    compared++;
    if (req_ok[1] !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_clear: ok1=%b, required 0", req_ok[1]);
    end
    serve(32'h0000_0105, a);
    req_cs = '0;
  endtask

  task automatic test_reset_in_ack();
    logic [AW-1:0] a;
    req_cs = 6'b000100; set_addr(2, 22'h000777);
    tick();
    rst_n = 1'b0; req_cs = '0;
    tick();
    compared++;
    if (sdram_rd !== 1'b0 || busy !== 1'b0 || req_ok !== '0) begin
      mismatched++;
      $display("FAIL rst_ack: rd=%b busy=%b ok=%b, required 0 0 000000", sdram_rd, busy, req_ok);
    end
    rst_n = 1'b1;
    sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_din = 32'hFFFF_FFFF;
    tick();
    sdram_ack = 1'b0; sdram_rdy = 1'b0;
    req_cs = 6'b000100; #1;
    compared++;
    if (sdram_rd !== 1'b0 || busy !== 1'b0 || req_ok !== '0) begin
      mismatched++;
      $display("FAIL rst_stray: rd=%b busy=%b ok=%b, required 0 0 000000", sdram_rd, busy, req_ok);
    end
    req_cs = 6'b100001; set_addr(0, 22'h000300); set_addr(5, 22'h000350);
    serve(32'h0000_0300, a);
    compared++;
    if (a !== 22'h000300) begin
      mismatched++;
      $display("FAIL rst_rr: first grant addr=%h, required 000300", a);
    end
    serve(32'h0000_0350, a);
    req_cs = '0;
  endtask

  task automatic test_ack_rdy_same();
    logic [AW-1:0] a;
    req_cs = 6'b001100; set_addr(2, 22'h000400); set_addr(3, 22'h000430);
    tick();
    compared++;
    if (sdram_rd !== 1'b1 || sdram_addr !== 22'h000400) begin
      mismatched++;
      $display("FAIL both_grant: rd=%b addr=%h, required 1 000400", sdram_rd, sdram_addr);
    end
    sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_din = 32'hDEAD_BEEF;
    tick();
    sdram_ack = 1'b0; sdram_rdy = 1'b0;
    compared++;
    if (sdram_rd !== 1'b0 || busy !== 1'b0 || req_ok[2] !== 1'b1 || rdata(2) !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL both_capture: rd=%b busy=%b ok=%b data=%h, required 0 0 1 deadbeef",
               sdram_rd, busy, req_ok[2], rdata(2));
    end
    tick();
    compared++;
    if (sdram_rd !== 1'b1 || sdram_addr !== 22'h000430) begin
      mismatched++;
      $display("FAIL both_next: rd=%b addr=%h, required 1 000430", sdram_rd, sdram_addr);
    end
    serve(32'h0000_0430, a);
    compared++;
    if (req_ok !== 6'b001100 || rdata(3) !== 32'h0000_0430) begin
      mismatched++;
      $display("FAIL both_final: ok=%b d3=%h, required 001100 00000430", req_ok, rdata(3));
    end
    req_cs = '0;
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_round_robin();
    test_addr_change();
    test_flush();
    test_reset_in_ack();
    test_ack_rdy_same();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/jts16_gfx_arb.md
Name: jts16_gfx_arb

Overview:
- Shares one SDRAM read port among the tile and sprite graphics fetchers of the S16 video path: char, map1, scr1, map2, scr2 and obj.
- Each requester keeps a one-entry tag/data buffer.
  - A hit returns ok with no SDRAM access.
  - Misses are served one at a time in round-robin order.
- Sits between the video layer fetchers and the SDRAM controller slot assigned to graphics.

Parameters:
N, 6, number of requesters (index 0=char, 1=map1, 2=scr1, 3=map2, 4=scr2, 5=obj).
AW, 22, word address width of every requester and of the SDRAM port.
DW, 32, data width; 16-bit requesters use bits [15:0].

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
flush  in  1  invalidates all buffers (used during ROM download / bank change)
req_cs  in  N  request strobe per requester; held high while waiting
req_addr  in  N*AW  packed addresses; requester i uses bits [i*AW +: AW]
req_ok  out  N  data for the current req_addr is valid
req_data  out  N*DW  packed per-requester data buffers
sdram_addr  out  AW  address presented to SDRAM
sdram_rd  out  1  read request; held until sdram_ack
sdram_ack  in  1  one-cycle pulse: controller accepted the address
sdram_rdy  in  1  one-cycle pulse: sdram_din valid
sdram_din  in  DW  SDRAM read data
busy  out  1  high from grant until data capture (or discard)

Behaviour:
- Clock and reset: one clock clk. rst_n is synchronous and active low. All state updates on the rising clk edge.
- Reset values:
  - state=IDLE, rr pointer=0.
  - All valid bits=0, tags=0, data buffers=0.
  - sdram_rd=0, sdram_addr=0, busy=0.
  - req_ok=0 in the cycle after reset, since all buffers are invalid.
- Hit rule (combinational): req_ok[i] = req_cs[i] & valid[i] & (req_addr[i]==tag[i]).
- miss[i] = req_cs[i] & ~req_ok[i].
- State machine: IDLE -> ACK -> DATA -> IDLE.
- IDLE:
  - If any miss[i] is set, grant = first index ≥ rr with a miss, wrapping modulo N.
  - Register sel=grant and sdram_addr=req_addr[grant]. Latch the pending tag. Set sdram_rd=1 and busy=1.
  - rr becomes (grant+1) mod N. Go to ACK.
  - If no miss, stay in IDLE and keep sdram_rd=0.
- ACK:
  - sdram_rd and sdram_addr are held stable.
  - On sdram_ack, clear sdram_rd and go to DATA.
  - If sdram_ack and sdram_rdy arrive in the same cycle, treat it as ack followed by rdy: capture the data and go straight to IDLE.
- DATA:
  - On sdram_rdy: data[sel]=sdram_din, tag[sel]=pending tag, valid[sel]=1. Clear busy and go to IDLE.
  - The requester sees req_ok the next cycle if its address still matches.
- Minimum miss latency: 3 cycles from req_cs to req_ok, with ack in the first ACK cycle and rdy one cycle later.
- An arbitration decision is taken only in IDLE. At most one transaction is outstanding.
- Requester changes req_addr while its fetch is in flight:
  - The transaction completes and stores the old tag.
  - req_ok stays low because the tag mismatches.
  - A new miss is raised in the following IDLE cycle.
- req_cs dropped mid-flight: the transaction completes and the data is stored. No abort.
- flush:
  - Clears all valid bits in that cycle.
  - If a transaction is in ACK/DATA, it still completes the SDRAM handshake, but the returned data is marked discard and valid is not set.
  - flush in the same cycle as sdram_rdy: flush wins and valid stays 0.
- Reset mid-operation:
  - Returns to IDLE immediately and drops sdram_rd.
  - Any later stray sdram_rdy/ack while in IDLE is ignored.
- Address width: requester addresses are zero-extended by the instantiating module. The arbiter does no arithmetic on addresses, only equality compare.
- Fairness: each requester with a persistent miss is served within N grants.

Test Plan:
- Single miss: reset, req_cs[2]=1, addr=22'h01234. ack 1 cycle after sdram_rd, rdy 1 cycle later with din=32'hA5A5_5A5A -> sdram_addr=22'h01234, req_ok[2]=1, req_data[2]=32'hA5A5_5A5A at cycle 3; a second request to the same address gives req_ok with no new sdram_rd.
- Round robin: misses on 0, 3 and 5 raised together with rr=0 -> grants in order 0, 3, 5. Then re-raise misses on 0 and 5 -> next grant is 0, since rr wrapped to 0 after granting 5.
- Address change in flight: req 1 at 22'h100, switched to 22'h104 before rdy -> tag[1]=22'h100, req_ok[1] stays 0, next sdram_addr=22'h104.
- flush during DATA: flush pulsed in the same cycle as sdram_rdy -> valid[sel]=0 and req_ok stays low; the requester is refetched.
- Reset in ACK: rst_n low while sdram_rd=1 -> next cycle sdram_rd=0, busy=0, all req_ok=0, rr=0.
- Simultaneous ack+rdy: both pulsed in the same cycle -> data captured, returns to IDLE, and the next pending miss is granted on the following cycle.
